req_gnt_responder: RTL and testbench

Grant-side responder for the single-channel req/gnt handshake. It samples a one-cycle request and answers with a one-cycle grant on the next clock. It then holds a mandatory one-cycle recovery slot with grant low. It also detects requester-side protocol violations and keeps saturating grant, drop and violation counters for debug readback. It sits opposite the requester, so the pair forms a protocol-clean req/gnt link that the existing req/gnt assertion checker can monitor.

---
 rtl/req_gnt_responder_if.sv | 25 ++
 rtl/req_gnt_responder.sv | 110 +++++++++++
 tb/tb_req_gnt_responder.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/req_gnt_responder_if.sv
// Handshake and debug-readback bundle between a req/gnt requester and the grant-side responder.
// Signal names keep the responder's _ip/_op view so both ends read the same way.
interface req_gnt_responder_if #(
   parameter int unsigned CNT_W = 16
);
   logic             req_ip;
   logic             enable_ip;
   logic             clr_ip;
   logic             gnt_op;
   logic             busy_op;
   logic             viol_op;
   logic [CNT_W-1:0] grant_cnt_op;
   logic [CNT_W-1:0] drop_cnt_op;
   logic [CNT_W-1:0] viol_cnt_op;

   modport master (
      output req_ip, enable_ip, clr_ip,
      input  gnt_op, busy_op, viol_op, grant_cnt_op, drop_cnt_op, viol_cnt_op
   );

   modport slave (
      input  req_ip, enable_ip, clr_ip,
      output gnt_op, busy_op, viol_op, grant_cnt_op, drop_cnt_op, viol_cnt_op
   );
endinterface

// File: rtl/req_gnt_responder.sv
// Grant-side req/gnt responder: one-cycle grant, one-cycle recovery slot, requester-violation
// detection and saturating grant/drop/violation counters. All outputs come straight from flops.
module req_gnt_responder #(
   parameter int unsigned CNT_W = 16
) (
   input  logic               clk_ip,
   input  logic               reset_n_ip,
   req_gnt_responder_if.slave rg_if
);
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StGnt   = 2'd1,
      StRecov = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   state_e           r_state;
   logic             r_gnt;
   logic             r_busy;
   logic             r_viol;
   logic [CNT_W-1:0] r_grant_cnt;
   logic [CNT_W-1:0] r_drop_cnt;
   logic [CNT_W-1:0] r_viol_cnt;

   logic w_idle;
   logic w_grant_evt;
   logic w_drop_evt;
   logic w_viol_evt;

   // enable_ip only matters in IDLE; any req seen during GNT/RECOV is a requester violation.
   assign w_idle      = (r_state == StIdle);
   assign w_grant_evt = w_idle & rg_if.req_ip & rg_if.enable_ip;
   assign w_drop_evt  = w_idle & rg_if.req_ip & ~rg_if.enable_ip;
   assign w_viol_evt  = ~w_idle & rg_if.req_ip;

   // A same-cycle event beats clear, so a cleared counter restarts at one.
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                 input logic             evt,
                                                 input logic             clr);
      logic [CNT_W-1:0] nxt;
      nxt = cnt;
      if (clr) begin
         nxt = evt ? CntOne : '0;
      end else if (evt && (cnt != CntMax)) begin
         nxt = cnt + CntOne;
      end
      return nxt;
   endfunction

   always_ff @(posedge clk_ip or negedge reset_n_ip) begin
      if (!reset_n_ip) begin
         r_state <= StIdle;
         r_gnt   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_grant_evt) begin
                  r_state <= StGnt;
                  r_gnt   <= 1'b1;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= StIdle;
                  r_gnt   <= 1'b0;
                  r_busy  <= 1'b0;
               end
            end
            StGnt: begin
               r_state <= StRecov;
               r_gnt   <= 1'b0;
               r_busy  <= 1'b1;
            end
            StRecov: begin
               r_state <= StIdle;
               r_gnt   <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= StIdle;
               r_gnt   <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_ip or negedge reset_n_ip) begin
      if (!reset_n_ip) begin
         r_viol      <= 1'b0;
         r_grant_cnt <= '0;
         r_drop_cnt  <= '0;
         r_viol_cnt  <= '0;
      end else begin
         r_viol      <= w_viol_evt | (r_viol & ~rg_if.clr_ip);
         r_grant_cnt <= cnt_next(r_grant_cnt, w_grant_evt, rg_if.clr_ip);
         r_drop_cnt  <= cnt_next(r_drop_cnt, w_drop_evt, rg_if.clr_ip);
         r_viol_cnt  <= cnt_next(r_viol_cnt, w_viol_evt, rg_if.clr_ip);
      end
   end

   assign rg_if.gnt_op       = r_gnt;
   assign rg_if.busy_op      = r_busy;
   assign rg_if.viol_op      = r_viol;
   assign rg_if.grant_cnt_op = r_grant_cnt;
   assign rg_if.drop_cnt_op  = r_drop_cnt;
   assign rg_if.viol_cnt_op  = r_viol_cnt;

endmodule

// File: tb/tb_req_gnt_responder.sv
// Bench for req_gnt_responder: directed scenarios plus randomized traffic against a
// timestamp-based model of the handshake rules; a CNT_W=2 copy covers saturation.
module tb_req_gnt_responder;
   localparam int unsigned W  = 16;
   localparam int unsigned SW = 2;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   req_gnt_responder_if #(.CNT_W(W))  bus ();
   req_gnt_responder_if #(.CNT_W(SW)) sbus ();

   req_gnt_responder #(.CNT_W(W)) dut (
      .clk_ip     (clk),
      .reset_n_ip (rst_n),
      .rg_if      (bus.slave)
   );

   req_gnt_responder #(.CNT_W(SW)) dut_s (
      .clk_ip     (clk),
      .reset_n_ip (rst_n),
      .rg_if      (sbus.slave)
   );

   // Model: a grant accepted at edge L owns edges L+1 and L+2; the next legal req is at L+3.
   int m_cycle = 0;
   int m_last  = -100;
   int m_grant, m_drop, m_vcnt;
   bit m_viol, m_gnt, m_busy;

   function automatic int sat_inc(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v < mx) ? v + 1 : v;
   endfunction

   task automatic model_reset();
      m_last  = -100;
      m_grant = 0;
      m_drop  = 0;
      m_vcnt  = 0;
      m_viol  = 1'b0;
      m_gnt   = 1'b0;
      m_busy  = 1'b0;
   endtask

   task automatic model_edge(input bit req, input bit en, input bit clr);
      int d;
      bit hs, g, dr, v;
      d  = m_cycle - m_last;
      hs = (d == 1) || (d == 2);
      g  = !hs && req && en;
      dr = !hs && req && !en;
      v  = hs && req;
      if (g) m_last = m_cycle;
      m_grant = clr ? int'(g)  : (g  ? sat_inc(m_grant, W) : m_grant);
      m_drop  = clr ? int'(dr) : (dr ? sat_inc(m_drop, W)  : m_drop);
      m_vcnt  = clr ? int'(v)  : (v  ? sat_inc(m_vcnt, W)  : m_vcnt);
      m_viol  = v || (m_viol && !clr);
      m_gnt   = (m_cycle == m_last);
      m_busy  = ((m_cycle - m_last) == 0) || ((m_cycle - m_last) == 1);
      m_cycle++;
   endtask

   task automatic step(input bit req, input bit en, input bit clr);
      bus.req_ip    = req;
      bus.enable_ip = en;
      bus.clr_ip    = clr;
      @(posedge clk);
      model_edge(req, en, clr);
      #1;
      bus.req_ip = 1'b0;
      bus.clr_ip = 1'b0;
   endtask

   // Drives only the small instance; the main bus sits idle and the model tracks that edge.
   task automatic sstep(input bit req, input bit en, input bit clr);
      sbus.req_ip    = req;
      sbus.enable_ip = en;
      sbus.clr_ip    = clr;
      @(posedge clk);
      model_edge(1'b0, bus.enable_ip, 1'b0);
      #1;
      sbus.req_ip = 1'b0;
      sbus.clr_ip = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.gnt_op !== 1'b0 || bus.busy_op !== 1'b0 || bus.viol_op !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_flags: got gnt=%b busy=%b viol=%b want 0 0 0",
                  bus.gnt_op, bus.busy_op, bus.viol_op);
      end
      n_checks++;
      if (bus.grant_cnt_op !== 16'd0 || bus.drop_cnt_op !== 16'd0 || bus.viol_cnt_op !== 16'd0)
      begin
         n_errors++;
         $display("FAIL reset_cnts: got %0d %0d %0d want 0 0 0",
                  bus.grant_cnt_op, bus.drop_cnt_op, bus.viol_cnt_op);
      end
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, 1'b0);
         n_checks++;
         if (bus.gnt_op !== 1'b0 || bus.busy_op !== 1'b0 || bus.viol_op !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset[%0d]: got gnt=%b busy=%b viol=%b want 0 0 0",
                     i, bus.gnt_op, bus.busy_op, bus.viol_op);
         end
      end
   endtask

   task automatic test_single();
      step(1'b0, 1'b1, 1'b1);
      repeat (4) step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (bus.gnt_op !== 1'b1 || bus.busy_op !== 1'b1) begin
         n_errors++;
         $display("FAIL single_gnt_cycle: got gnt=%b busy=%b want 1 1", bus.gnt_op, bus.busy_op);
      end
      n_checks++;
      if (bus.grant_cnt_op !== 16'd1) begin
         n_errors++;
         $display("FAIL single_grant_cnt: got %0d want 1", bus.grant_cnt_op);
      end
      step(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (bus.gnt_op !== 1'b0 || bus.busy_op !== 1'b1) begin
         n_errors++;
         $display("FAIL single_recov_cycle: got gnt=%b busy=%b want 0 1", bus.gnt_op, bus.busy_op);
      end
      step(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (bus.gnt_op !== 1'b0 || bus.busy_op !== 1'b0 || bus.viol_op !== 1'b0) begin
         n_errors++;
         $display("FAIL single_back_idle: got gnt=%b busy=%b viol=%b want 0 0 0",
                  bus.gnt_op, bus.busy_op, bus.viol_op);
      end
   endtask

   task automatic test_back_to_back();
      int seen;
      seen = 0;
      step(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (bus.gnt_op === 1'b1) seen++;
         step(1'b0, 1'b1, 1'b0);
         if (bus.gnt_op !== 1'b0) seen += 100;
         step(1'b0, 1'b1, 1'b0);
         if (bus.gnt_op !== 1'b0) seen += 100;
      end
      n_checks++;
      if (seen != 8) begin
         n_errors++;
         $display("FAIL b2b_gnt_pattern: got score %0d want 8", seen);
      end
      n_checks++;
      if (bus.grant_cnt_op !== 16'd8 || bus.viol_cnt_op !== 16'd0 || bus.viol_op !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b_counts: got grant=%0d vcnt=%0d viol=%b want 8 0 0",
                  bus.grant_cnt_op, bus.viol_cnt_op, bus.viol_op);
      end
   endtask

   task automatic test_violation();
      logic [3:0] pat;
      step(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b0);
         pat[i] = bus.gnt_op;
      end
      n_checks++;
      if (pat !== 4'b1001) begin
         n_errors++;
         $display("FAIL viol_gnt_pattern: got %b want 1001", pat);
      end
      n_checks++;
      if (bus.viol_op !== 1'b1 || bus.viol_cnt_op !== 16'd2 || bus.grant_cnt_op !== 16'd2) begin
         n_errors++;
         $display("FAIL viol_counts: got viol=%b vcnt=%0d grant=%0d want 1 2 2",
                  bus.viol_op, bus.viol_cnt_op, bus.grant_cnt_op);
      end
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      n_checks++;
      if (bus.viol_op !== 1'b0 || bus.viol_cnt_op !== 16'd0 || bus.grant_cnt_op !== 16'd0 ||
          bus.drop_cnt_op !== 16'd0) begin
         n_errors++;
         $display("FAIL clear_all: got viol=%b vcnt=%0d grant=%0d drop=%0d want 0 0 0 0",
                  bus.viol_op, bus.viol_cnt_op, bus.grant_cnt_op, bus.drop_cnt_op);
      end
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      n_checks++;
      if (bus.viol_op !== 1'b1 || bus.viol_cnt_op !== 16'd1 || bus.grant_cnt_op !== 16'd0) begin
         n_errors++;
         $display("FAIL clear_vs_viol: got viol=%b vcnt=%0d grant=%0d want 1 1 0",
                  bus.viol_op, bus.viol_cnt_op, bus.grant_cnt_op);
      end
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      n_checks++;
      if (bus.gnt_op !== 1'b1 || bus.grant_cnt_op !== 16'd1 || bus.viol_op !== 1'b0 ||
          bus.viol_cnt_op !== 16'd0) begin
         n_errors++;
         $display("FAIL clear_vs_grant: got gnt=%b grant=%0d viol=%b vcnt=%0d want 1 1 0 0",
                  bus.gnt_op, bus.grant_cnt_op, bus.viol_op, bus.viol_cnt_op);
      end
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_disable();
      int bad;
      bad = 0;
      step(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (bus.busy_op !== 1'b1 || bus.viol_cnt_op !== 16'd1 || bus.drop_cnt_op !== 16'd0) begin
         n_errors++;
         $display("FAIL enable_in_flight: got busy=%b vcnt=%0d drop=%0d want 1 1 0",
                  bus.busy_op, bus.viol_cnt_op, bus.drop_cnt_op);
      end
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (bus.gnt_op !== 1'b0 || bus.busy_op !== 1'b0) bad++;
         step(1'b0, 1'b0, 1'b0);
         if (bus.gnt_op !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL disabled_no_gnt: got %0d bad cycles want 0", bad);
      end
      n_checks++;
      if (bus.drop_cnt_op !== 16'd5 || bus.grant_cnt_op !== 16'd1) begin
         n_errors++;
         $display("FAIL drop_cnt: got drop=%0d grant=%0d want 5 1",
                  bus.drop_cnt_op, bus.grant_cnt_op);
      end
      step(1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_saturation();
      int exp_g;
      sstep(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         sstep(1'b1, 1'b1, 1'b0);
         exp_g = (i + 1 < 3) ? i + 1 : 3;
         n_checks++;
         if (sbus.gnt_op !== 1'b1 || sbus.grant_cnt_op !== 2'(exp_g)) begin
            n_errors++;
            $display("FAIL sat_grant[%0d]: got gnt=%b cnt=%0d want 1 %0d",
                     i, sbus.gnt_op, sbus.grant_cnt_op, exp_g);
         end
         sstep(1'b0, 1'b1, 1'b0);
         sstep(1'b0, 1'b1, 1'b0);
      end
      repeat (6) sstep(1'b1, 1'b1, 1'b0);
      sstep(1'b0, 1'b1, 1'b0);
      sstep(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (sbus.viol_cnt_op !== 2'd3 || sbus.viol_op !== 1'b1 || sbus.grant_cnt_op !== 2'd3) begin
         n_errors++;
         $display("FAIL sat_viol: got vcnt=%0d viol=%b grant=%0d want 3 1 3",
                  sbus.viol_cnt_op, sbus.viol_op, sbus.grant_cnt_op);
      end
      for (int i = 0; i < 4; i++) sstep(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (sbus.drop_cnt_op !== 2'd3) begin
         n_errors++;
         $display("FAIL sat_drop: got %0d want 3", sbus.drop_cnt_op);
      end
      sstep(1'b0, 1'b1, 1'b1);
      n_checks++;
      if (sbus.grant_cnt_op !== 2'd0 || sbus.drop_cnt_op !== 2'd0 || sbus.viol_cnt_op !== 2'd0)
      begin
         n_errors++;
         $display("FAIL sat_clear: got %0d %0d %0d want 0 0 0",
                  sbus.grant_cnt_op, sbus.drop_cnt_op, sbus.viol_cnt_op);
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      bad = 0;
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (bus.gnt_op !== 1'b1) begin
         n_errors++;
         $display("FAIL mid_pre_gnt: got %b want 1", bus.gnt_op);
      end
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.gnt_op !== 1'b0 || bus.busy_op !== 1'b0 || bus.grant_cnt_op !== 16'd0) begin
         n_errors++;
         $display("FAIL mid_async_reset: got gnt=%b busy=%b grant=%0d want 0 0 0",
                  bus.gnt_op, bus.busy_op, bus.grant_cnt_op);
      end
      #2 rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 1'b0);
         if (bus.gnt_op !== 1'b0 || bus.busy_op !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL mid_no_replay: got %0d bad cycles want 0", bad);
      end
      step(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (bus.gnt_op !== 1'b1 || bus.grant_cnt_op !== 16'd1) begin
         n_errors++;
         $display("FAIL mid_fresh_gnt: got gnt=%b grant=%0d want 1 1", bus.gnt_op, bus.grant_cnt_op);
      end
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      bit req, en, clr;
      for (int i = 0; i < 400; i++) begin
         req = ($urandom_range(0, 99) < 45);
         en  = ($urandom_range(0, 99) < 85);
         clr = ($urandom_range(0, 99) < 4);
         step(req, en, clr);
         n_checks++;
         if (bus.gnt_op !== m_gnt || bus.busy_op !== m_busy || bus.viol_op !== m_viol) begin
            n_errors++;
            $display("FAIL rand_flags[%0d]: got gnt=%b busy=%b viol=%b want %b %b %b",
                     i, bus.gnt_op, bus.busy_op, bus.viol_op, m_gnt, m_busy, m_viol);
         end
         n_checks++;
         if (bus.grant_cnt_op !== 16'(m_grant) || bus.drop_cnt_op !== 16'(m_drop) ||
             bus.viol_cnt_op !== 16'(m_vcnt)) begin
            n_errors++;
            $display("FAIL rand_cnts[%0d]: got %0d %0d %0d want %0d %0d %0d", i,
                     bus.grant_cnt_op, bus.drop_cnt_op, bus.viol_cnt_op, m_grant, m_drop, m_vcnt);
         end
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.req_ip     = 1'b0;
      bus.enable_ip  = 1'b1;
      bus.clr_ip     = 1'b0;
      sbus.req_ip    = 1'b0;
      sbus.enable_ip = 1'b1;
      sbus.clr_ip    = 1'b0;
      model_reset();
      test_reset();
      test_single();
      test_back_to_back();
      test_violation();
      test_disable();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
